adder4_sum_accumulator: RTL and testbench
=========================================

// Module: adder4_sum_accumulator
// PURPOSE
//   Downstream stage of the 4-bit adder. Consumes its 5-bit sums over a valid/ready
//   handshake and accumulates COUNT sums per frame into an ACC_W-bit total.
//   Presents the total on a registered valid/ready output port.
//   Frame-level reduction point between the adder datapath and its consumer.
// PARAMETERS
//   SUM_W  5  width of the incoming sum, matching the 4-bit adder output
//   ACC_W  8  width of the accumulated total; must be >= SUM_W
//   COUNT  4  sums per frame; must be >= 1
// PORTS
//   clk        in   1       single clock; all state updates on the rising edge
//   rst_n      in   1       reset, synchronous, active-low
//   clear      in   1       synchronous frame abort
//   in_valid   in   1       in_sum is valid
//   in_ready   out  1       block can accept a sum
//   in_sum     in   SUM_W   sum from the 4-bit adder, unsigned
//   out_valid  out  1       out_total, out_ovf are valid
//   out_ready  in   1       consumer accepts the output
//   out_total  out  ACC_W   frame total
//   out_ovf    out  1       frame total exceeded 2^ACC_W-1
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge)
//     state=ACC, acc=0, cnt=0, ovf=0.
//     out_valid=0, out_total=0, out_ovf=0, in_ready=1 after that edge.
//   FSM with two states, ACC and DONE.
//   ACC
//     in_ready=1, out_valid=0. A sum is accepted when in_valid & in_ready.
//     On accept: acc <= acc + in_sum, computed ACC_W+1 wide.
//     On accept: ovf <= ovf | carry(ACC_W), where carry(ACC_W) is bit ACC_W of that sum.
//     On accept: cnt <= cnt + 1.
//     If the accept brings the accepted count to COUNT (cnt==COUNT-1 before the edge):
//       go to DONE; out_total and out_ovf are loaded from the updated values at the same edge.
//       Latency: out_valid=1 in the cycle after the last sum is accepted.
//   DONE
//     in_ready=0, out_valid=1. out_total and out_ovf stay stable until the handshake.
//     On out_valid & out_ready: go to ACC with acc=0, cnt=0, ovf=0.
//       in_ready=1 in the next cycle. No bypass: at least one bubble cycle per frame.
//   clear (sync, any state)
//     Next state ACC; acc, cnt, ovf are zeroed; out_valid drops.
//     A partial frame, or an unconsumed total, is discarded.
//     clear has priority over accept and over output handshake in the same cycle.
//     rst_n=0 has priority over clear.
//   cnt wraps only through the DONE return path; it never exceeds COUNT-1 in ACC.
//   COUNT=1: every accepted sum produces a frame.
//   Inputs with in_valid=0 are ignored; in_sum is don't-care then.
//   Reset mid-frame or in DONE: the frame is lost and the block returns to the reset state.
// CONFIGURATION
//   Macro: ADDER4_SUM_ACC_SAT_EN
//   Defined
//     When the wide add carries out, acc saturates to {ACC_W{1'b1}} and stays saturated
//     for the rest of the frame. out_ovf=1 for that frame.
//   Undefined
//     acc wraps modulo 2^ACC_W. out_ovf is still reported and remains sticky for the frame.
// TESTING
//   T1 Reset: assert rst_n=0 for 2 clk -> out_valid=0, out_total=0, out_ovf=0, in_ready=1.
//   T2 Defaults, frame 3,7,30,1 back-to-back -> 1 cycle after 4th accept:
//        out_valid=1, out_total=41, out_ovf=0, in_ready=0.
//   T3 Hold out_ready=0 for 5 cycles after T2 -> out_total stays 41.
//        Then out_ready=1 for 1 cycle -> out_valid=0 and in_ready=1 on the next cycle.
//   T4 ACC_W=6, frame 30,30,30,30 -> out_ovf=1.
//        out_total=56 without ADDER4_SUM_ACC_SAT_EN; out_total=63 with it.
//   T5 Accept 5,9, then clear together with in_valid=1 (sum 4) -> sum 4 is dropped.
//        Next frame 1,1,1,1 -> out_total=4.
//   T6 Stall: in_valid toggles 1/0 over 8 cycles with sums 2,2,2,2 -> exactly one output, out_total=8.
//        Assert clear while out_valid=1 -> out_valid=0 next cycle; no frame is delivered.

Source files
------------

// File: rtl/adder4_sum_accumulator.sv
// rtl/adder4_sum_accumulator.sv - Frame accumulator for 4-bit adder sums (option: ADDER4_SUM_ACC_SAT_EN)
module adder4_sum_accumulator #(
    parameter int SUM_W = 5,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ST_ACC,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             tovf_q, tovf_d;

    logic [ACC_W:0]   wide_sum;
    logic [ACC_W-1:0] acc_next;
    logic             ovf_next;

    assign wide_sum = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
    assign ovf_next = ovf_q | wide_sum[ACC_W];

`ifdef ADDER4_SUM_ACC_SAT_EN
    // Once the frame has overflowed, acc is pinned at full scale for the rest of it.
    assign acc_next = ovf_next ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    assign acc_next = wide_sum[ACC_W-1:0];
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        total_d = total_q;
        tovf_d  = tovf_q;

        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_next;
                    ovf_d = ovf_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                        total_d = acc_next;
                        tovf_d  = ovf_next;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ST_ACC;
        endcase

        // Abort wins over both accept and output handshake.
        if (clear) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
            tovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
            tovf_q  <= tovf_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_total = total_q;
    assign out_ovf   = tovf_q;

endmodule

// File: tb/tb_adder4_sum_accumulator.sv
// tb/tb_adder4_sum_accumulator.sv - Self-checking bench with frame-level reference model
module tb_adder4_sum_accumulator;

    localparam int COUNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] in_sum = '0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_valid8, out_ovf8;
    logic [7:0] out_total8;
    logic       in_ready6, out_valid6, out_ovf6;
    logic [5:0] out_total6;

    int total = 0;
    int bad = 0;

    int m_sum, m_cnt, m_tot;
    bit m_pend;

    always #5 clk = ~clk;

    adder4_sum_accumulator #(.SUM_W(5), .ACC_W(8), .COUNT(COUNT)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .in_sum(in_sum),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_total(out_total8), .out_ovf(out_ovf8)
    );

    adder4_sum_accumulator #(.SUM_W(5), .ACC_W(6), .COUNT(COUNT)) dut6 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready6), .in_sum(in_sum),
        .out_valid(out_valid6), .out_ready(out_ready),
        .out_total(out_total6), .out_ovf(out_ovf6)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_total(input int raw, input int w);
        int maxv;
        maxv = (1 << w) - 1;
        if (raw <= maxv) return raw;
`ifdef ADDER4_SUM_ACC_SAT_EN
        return maxv;
`else
        return raw % (1 << w);
`endif
    endfunction

    // Frame-level view: a running arithmetic sum and a list length, nothing more.
    task automatic model_edge();
        if (!rst_n) begin
            m_sum = 0; m_cnt = 0; m_pend = 0; m_tot = 0;
        end else if (clear) begin
            m_sum = 0; m_cnt = 0; m_pend = 0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 0;
        end else if (in_valid) begin
            m_sum += int'(in_sum);
            m_cnt++;
            if (m_cnt == COUNT) begin
                m_pend = 1; m_tot = m_sum; m_sum = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid8", int'(out_valid8), int'(m_pend));
        chk("in_ready8", int'(in_ready8), int'(!m_pend));
        chk("out_valid6", int'(out_valid6), int'(m_pend));
        chk("in_ready6", int'(in_ready6), int'(!m_pend));
        if (m_pend) begin
            chk("out_total8", int'(out_total8), exp_total(m_tot, 8));
            chk("out_ovf8", int'(out_ovf8), int'(m_tot > 255));
            chk("out_total6", int'(out_total6), exp_total(m_tot, 6));
            chk("out_ovf6", int'(out_ovf6), int'(m_tot > 63));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input int s);
        in_valid = 1'b1;
        in_sum = 5'(s);
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        int rises;
        logic prev_v;
        int t4[4];
        int t2[4];
        t2 = '{3, 7, 30, 1};
        t4 = '{30, 30, 30, 30};
        m_sum = 0; m_cnt = 0; m_pend = 0; m_tot = 0;

        // T1 reset
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("t1_out_valid", int'(out_valid8), 0);
        chk("t1_out_total", int'(out_total8), 0);
        chk("t1_out_ovf", int'(out_ovf8), 0);
        chk("t1_in_ready", int'(in_ready8), 1);
        rst_n = 1'b1;

        // T2 back-to-back frame
        for (int i = 0; i < 4; i++) push(t2[i]);
        chk("t2_out_valid", int'(out_valid8), 1);
        chk("t2_out_total", int'(out_total8), 41);
        chk("t2_out_ovf", int'(out_ovf8), 0);
        chk("t2_in_ready", int'(in_ready8), 0);

        // T3 hold then handshake
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_hold_total", int'(out_total8), 41);
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t3_out_valid", int'(out_valid8), 0);
        chk("t3_in_ready", int'(in_ready8), 1);

        // T4 overflow on the narrow instance
        for (int i = 0; i < 4; i++) push(t4[i]);
        chk("t4_ovf6", int'(out_ovf6), 1);
`ifdef ADDER4_SUM_ACC_SAT_EN
        chk("t4_total6", int'(out_total6), 63);
`else
        chk("t4_total6", int'(out_total6), 56);
`endif
        chk("t4_total8", int'(out_total8), 120);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // T5 clear drops a partial frame and the sum offered with it
        push(5);
        push(9);
        clear = 1'b1;
        push(4);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) push(1);
        chk("t5_total", int'(out_total8), 4);
        chk("t5_valid", int'(out_valid8), 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // T6 stalled input, then clear discards the unconsumed total
        rises = 0;
        prev_v = out_valid8;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_sum = 5'd2;
            cycle();
            if (out_valid8 && !prev_v) rises++;
            prev_v = out_valid8;
        end
        in_valid = 1'b0;
        chk("t6_outputs", rises, 1);
        chk("t6_total", int'(out_total8), 8);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("t6_clear_valid", int'(out_valid8), 0);
        cycle();
        chk("t6_after_valid", int'(out_valid8), 0);

        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sum = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
